// File: rtl/fb_video_capture.sv
// Captures RGB888 video (HS/VS/DE) and emits RGB555 framebuffer write words through a small FIFO.
// Build option: define FBCAP_ROUND_EN for saturating round-to-nearest colour reduction instead of truncation.
module fb_video_capture #(
  parameter int pHRES    = 1280,
  parameter int pVRES    = 720,
  parameter int pFIFO_AW = 4
) (
  input  logic        iCLK,
  input  logic        iRESETn,
  input  logic [7:0]  iRED,
  input  logic [7:0]  iGRN,
  input  logic [7:0]  iBLU,
  input  logic        iHS,
  input  logic        iVS,
  input  logic        iDE,
  output logic        oFB_START,
  output logic [14:0] oFB_DATA,
  output logic        oFB_DATAVALID,
  input  logic        iFB_READY,
  output logic        oOVERFLOW,
  output logic [7:0]  oFRAME_CNT
);

  localparam int HW    = $clog2(pHRES + 1);
  localparam int VW    = $clog2(pVRES + 1);
  localparam int DEPTH = 1 << pFIFO_AW;

  typedef enum logic [1:0] {SYNC_WAIT, ARMED, CAPTURE, DROP} CapState;

  function automatic logic [4:0] toFive(input logic [7:0] c8);
`ifdef FBCAP_ROUND_EN
    logic [8:0] sum;
    sum = {1'b0, c8} + 9'd4;
    return sum[8] ? 5'd31 : sum[7:3];
`else
    return c8[7:3];
`endif
  endfunction

  logic [7:0]  s1Red, s1Grn, s1Blu;
  logic        s1Vs, s1De, vsPrev, dePrev;
  logic        vsRise, deFall;
  CapState     state;
  logic [HW-1:0] pixCnt;
  logic [VW-1:0] lineCnt;
  logic        inWindow, startPix, capPix, pushReq, pushOk, pop;
  logic [14:0] pixWord;
  logic [15:0] fifoMem [DEPTH];
  logic [pFIFO_AW:0] wrPtr, rdPtr;
  logic        fifoEmpty, fifoFull;

  // Single input register stage; the delayed copies give VS rise / DE fall detection on S1
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      s1Red  <= '0;
      s1Grn  <= '0;
      s1Blu  <= '0;
      s1Vs   <= 1'b0;
      s1De   <= 1'b0;
      vsPrev <= 1'b0;
      dePrev <= 1'b0;
    end else begin
      s1Red  <= iRED;
      s1Grn  <= iGRN;
      s1Blu  <= iBLU;
      s1Vs   <= iVS;
      s1De   <= iDE;
      vsPrev <= s1Vs;
      dePrev <= s1De;
    end
  end

  assign vsRise  = s1Vs && !vsPrev;
  assign deFall  = dePrev && !s1De;
  assign pixWord = {toFive(s1Red), toFive(s1Grn), toFive(s1Blu)};

  assign fifoEmpty     = (wrPtr == rdPtr);
  assign fifoFull      = (wrPtr[pFIFO_AW] != rdPtr[pFIFO_AW]) &&
                         (wrPtr[pFIFO_AW-1:0] == rdPtr[pFIFO_AW-1:0]);
  assign oFB_DATAVALID = !fifoEmpty;
  assign {oFB_START, oFB_DATA} = fifoMem[rdPtr[pFIFO_AW-1:0]];
  assign pop           = oFB_DATAVALID && iFB_READY;

  // A VS rise coinciding with a DE pixel makes that pixel the frame's start pixel
  always_comb begin
    inWindow = (pixCnt < HW'(pHRES)) && (lineCnt < VW'(pVRES));
    startPix = s1De && (vsRise || (state == ARMED));
    capPix   = s1De && !vsRise && (state == CAPTURE) && inWindow;
    pushReq  = startPix || capPix;
    pushOk   = pushReq && (!fifoFull || pop);
  end

  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      state      <= SYNC_WAIT;
      pixCnt     <= '0;
      lineCnt    <= '0;
      oOVERFLOW  <= 1'b0;
      oFRAME_CNT <= '0;
    end else if (startPix) begin
      oFRAME_CNT <= oFRAME_CNT + 8'd1;
      lineCnt    <= '0;
      if (pushOk) begin
        oOVERFLOW <= 1'b0;
        pixCnt    <= HW'(1);
        state     <= CAPTURE;
      end else begin
        oOVERFLOW <= 1'b1;
        pixCnt    <= '0;
        state     <= DROP;
      end
    end else if (vsRise) begin
      state   <= ARMED;
      pixCnt  <= '0;
      lineCnt <= '0;
    end else if (state == CAPTURE) begin
      if (capPix) begin
        if (pushOk) begin
          pixCnt <= pixCnt + HW'(1);
        end else begin
          oOVERFLOW <= 1'b1;
          state     <= DROP;
        end
      end else if (deFall) begin
        pixCnt <= '0;
        if (lineCnt < VW'(pVRES)) lineCnt <= lineCnt + VW'(1);
      end
    end
  end

  // Extra pointer MSB separates full from empty; a push into a full FIFO rides on a same-cycle pop
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      wrPtr <= '0;
      rdPtr <= '0;
      for (int i = 0; i < DEPTH; i++) fifoMem[i] <= '0;
    end else begin
      if (pushOk) begin
        fifoMem[wrPtr[pFIFO_AW-1:0]] <= {startPix, pixWord};
        wrPtr <= wrPtr + 1'b1;
      end
      if (pop) rdPtr <= rdPtr + 1'b1;
    end
  end

endmodule
